// File: rtl/alu_mc.sv
// Purpose: multi-cycle ALU for the multi-cycle core. Single-cycle ops plus an iterative
//   shift-add multiplier and an optional restoring divider (present when ALU_DIV_EN is defined).
// Latency: accept edge to out_valid is 1 cycle for ops 0-9/E/F, WIDTH+1 cycles for ops A-D.
// Backpressure: result/zero are held while out_valid && !out_ready; in_ready stays low until the
//   output handshake edge, and no new op is taken on that same edge.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake; op (4b), a, b (WIDTH) latched on accept
//   out_valid/out_ready result handshake; result (WIDTH), zero (result==0) registered
//   busy                high while an iterative op is being computed
module alu_mc #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               sel_hi;   // MULHU/REMU take the upper half of the work register
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}

  // ---------------- single-cycle ops, computed straight from the inputs ----------------
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sres;
  logic             slt_s, slt_u;
  logic             is_mul, is_div;

  assign sh    = b[SHW-1:0];
  assign slt_s = $signed(a) < $signed(b);
  assign slt_u = a < b;
  assign is_mul = (op == 4'hA) || (op == 4'hB);

  always_comb begin
    sres = '0;
    case (op)
      4'h0: sres = a + b;
      4'h1: sres = a - b;
      4'h2: sres = a & b;
      4'h3: sres = a | b;
      4'h4: sres = {{(WIDTH-1){1'b0}}, slt_s};
      4'h5: sres = {{(WIDTH-1){1'b0}}, slt_u};
      4'h6: sres = a ^ b;
      4'h7: sres = a << sh;
      4'h8: sres = a >> sh;
      4'h9: sres = $unsigned($signed(a) >>> sh);
      default: sres = '0;  // reserved (and C/D when no divider is built)
    endcase
  end

  // ---------------- iterative step ----------------
  // Shift-add, LSB-first: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole register right by one.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, step_next;
  logic [WIDTH-1:0]   fin;

  assign mul_addend = acc[0] ? mcand : '0;
  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic               sel_div;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH:0]     div_shl, div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign is_div = (op == 4'hC) || (op == 4'hD);

  // Restoring step: shift the next dividend bit into the remainder, subtract the divisor
  // and keep the difference only if it did not go negative. A zero divisor always
  // "succeeds", which yields an all-ones quotient and remainder == dividend.
  assign div_shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_shl - {1'b0, dvsr};
  assign div_next = div_diff[WIDTH] ? {div_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign step_next = sel_div ? div_next : mul_next;
`else
  assign is_div    = 1'b0;
  assign step_next = mul_next;
`endif

  // Low half: MUL product / DIVU quotient. High half: MULHU product / REMU remainder.
  assign fin = sel_hi ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      cnt       <= '0;
      sel_hi    <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
`ifdef ALU_DIV_EN
      sel_div   <= 1'b0;
      dvsr      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            cnt      <= '0;
            sel_hi   <= op[0];
            mcand    <= a;
`ifdef ALU_DIV_EN
            sel_div  <= is_div;
            dvsr     <= b;
`endif
            if (is_mul || is_div) begin
              acc   <= is_mul ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              result    <= sres;
              zero      <= (sres == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          // The last step's output is taken directly from the step logic so the
          // result lands on the same edge as the final iteration.
          if (cnt == LAST) begin
            result    <= fin;
            zero      <= (fin == '0);
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
